// File: rtl/onion_intr_ctrl.sv
// ---------------------------------------------------------------------------
// onion_intr_ctrl
// Interrupt controller for the four TIMER outputs that drive FPGA_INTR.
// It is one Wishbone slave behind its own base-address chip-select.
// Each source is synchronized, rising-edge detected, latched as pending and
// counted in a saturating counter. Each pending bit can be masked, forced by
// software and cleared by a write of 1. FPGA_INTR_o is a registered level.
//
// Register map (byte offsets, decoded from WBs_ADR_i[9:2]):
//   0x00 PENDING  RO     0x04 ENABLE  RW     0x08 CLEAR  W1C (reads 0)
//   0x0C FORCE W1S (reads 0)     0x10 RAW (synchronized level) RO
//   0x14 COUNT {cnt3,cnt2,cnt1,cnt0} RO     other offsets read DEF_REG_VALUE
//
// Ports:
//   WBs_CLK_i       clock for all logic
//   WBs_RST_n_i     synchronous reset, active-low
//   WBs_ADR_i       byte address within the aperture
//   WBs_CYC_i       cycle strobe (already qualified by the base decode)
//   WBs_STB_i       transfer strobe
//   WBs_WE_i        1 = write
//   WBs_BYTE_STB_i  byte enables, only [0] gates writes
//   WBs_DAT_i       write data
//   WBs_DAT_o       read data, valid while WBs_ACK_o = 1
//   WBs_ACK_o       single-cycle acknowledge
//   SRC_i           raw asynchronous interrupt sources
//   FPGA_INTR_o     level-high interrupt requests
// ---------------------------------------------------------------------------
module onion_intr_ctrl #(
   parameter int          ADDRWIDTH     = 10,
   parameter int          NUM_SRC       = 4,
   parameter int          CNT_WIDTH     = 8,
   parameter logic [31:0] DEF_REG_VALUE = 32'hDEF_FAB_AC
) (
   input  logic                 WBs_CLK_i,
   input  logic                 WBs_RST_n_i,
   input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
   input  logic                 WBs_CYC_i,
   input  logic                 WBs_STB_i,
   input  logic                 WBs_WE_i,
   input  logic [3:0]           WBs_BYTE_STB_i,
   input  logic [31:0]          WBs_DAT_i,
   output logic [31:0]          WBs_DAT_o,
   output logic                 WBs_ACK_o,
   input  logic [NUM_SRC-1:0]   SRC_i,
   output logic [NUM_SRC-1:0]   FPGA_INTR_o
);

   localparam int OFFW = ADDRWIDTH - 2;

   localparam logic [OFFW-1:0] OFF_PENDING = OFFW'(8'h00);
   localparam logic [OFFW-1:0] OFF_ENABLE  = OFFW'(8'h01);
   localparam logic [OFFW-1:0] OFF_CLEAR   = OFFW'(8'h02);
   localparam logic [OFFW-1:0] OFF_FORCE   = OFFW'(8'h03);
   localparam logic [OFFW-1:0] OFF_RAW     = OFFW'(8'h04);
   localparam logic [OFFW-1:0] OFF_COUNT   = OFFW'(8'h05);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   // source path: s1/s2 synchronize, s3 holds the previous synchronized level
   logic [NUM_SRC-1:0]   s1_q, s2_q, s3_q;
   logic [NUM_SRC-1:0]   pending_q, pending_d;
   logic [NUM_SRC-1:0]   enable_q, enable_d;
   logic [NUM_SRC-1:0]   intr_q, intr_d;
   logic                 ack_q, ack_d;
   logic [CNT_WIDTH-1:0] cnt_q [NUM_SRC];
   logic [CNT_WIDTH-1:0] cnt_d [NUM_SRC];

   logic [OFFW-1:0]      reg_off_s;
   logic                 wr_s;
   logic [NUM_SRC-1:0]   edge_s;
   logic [NUM_SRC-1:0]   clear_wr_s;
   logic [NUM_SRC-1:0]   force_wr_s;
   logic [31:0]          count_s;
   logic                 unused_s;

   assign reg_off_s = WBs_ADR_i[ADDRWIDTH-1:2];
   assign edge_s    = s2_q & ~s3_q;
   assign unused_s  = ^{WBs_ADR_i[1:0], WBs_BYTE_STB_i[3:1], WBs_DAT_i[31:NUM_SRC]};

   // bus decode: a write commits on the same edge that raises ACK
   always_comb begin
      ack_d      = WBs_CYC_i & WBs_STB_i & ~ack_q;
      wr_s       = ack_d & WBs_WE_i & WBs_BYTE_STB_i[0];
      clear_wr_s = '0;
      force_wr_s = '0;
      enable_d   = enable_q;
      if (wr_s) begin
         case (reg_off_s)
            OFF_ENABLE: enable_d   = WBs_DAT_i[NUM_SRC-1:0];
            OFF_CLEAR:  clear_wr_s = WBs_DAT_i[NUM_SRC-1:0];
            OFF_FORCE:  force_wr_s = WBs_DAT_i[NUM_SRC-1:0];
            default:    enable_d   = enable_q;
         endcase
      end else begin
         enable_d = enable_q;
      end
   end

   // pending, counters and interrupt output next state; a set beats a clear
   always_comb begin
      pending_d = edge_s | force_wr_s | (pending_q & ~clear_wr_s);
      intr_d    = pending_q & enable_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (clear_wr_s[i]) begin
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i];
         end
         // clear-then-increment makes a coincident clear and edge read as 1
         if (edge_s[i] && (cnt_d[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_d[i] + CNT_WIDTH'(1);
         end else begin
            cnt_d[i] = cnt_d[i];
         end
      end
   end

   // pack the per-source counters into the COUNT register image
   always_comb begin
      count_s = 32'h0000_0000;
      for (int i = 0; i < NUM_SRC; i++) begin
         count_s[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      end
   end

   // read data is a pure decode of the current address and state
   always_comb begin
      case (reg_off_s)
         OFF_PENDING: WBs_DAT_o = {{(32-NUM_SRC){1'b0}}, pending_q};
         OFF_ENABLE:  WBs_DAT_o = {{(32-NUM_SRC){1'b0}}, enable_q};
         OFF_CLEAR:   WBs_DAT_o = 32'h0000_0000;
         OFF_FORCE:   WBs_DAT_o = 32'h0000_0000;
         OFF_RAW:     WBs_DAT_o = {{(32-NUM_SRC){1'b0}}, s2_q};
         OFF_COUNT:   WBs_DAT_o = count_s;
         default:     WBs_DAT_o = DEF_REG_VALUE;
      endcase
   end

   // state registers; reset wins over any bus or source event
   always_ff @(posedge WBs_CLK_i) begin
      if (!WBs_RST_n_i) begin
         s1_q      <= '0;
         s2_q      <= '0;
         s3_q      <= '0;
         pending_q <= '0;
         enable_q  <= '0;
         intr_q    <= '0;
         ack_q     <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q      <= SRC_i;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         pending_q <= pending_d;
         enable_q  <= enable_d;
         intr_q    <= intr_d;
         ack_q     <= ack_d;
         for (int i = 0; i < NUM_SRC; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign WBs_ACK_o   = ack_q;
   assign FPGA_INTR_o = intr_q;

endmodule
